qsn_merge_len17: RTL

- Downstream merge and control stage of the 17-lane QSN cyclic shifter.
- Accepts a shift factor with input valid and drives the select codes for the left and right QSN barrel shifters in the same cycle.
- Realigns the shift factor and valid with the shifters' 1-cycle latency, then merges the two shifter outputs under a lane mask into one registered cyclic-shift result.
- Sits between the permutation address generator and the layered check-node/variable-node message buffers.

---
 rtl/qsn_merge_len17_pkg.sv | 26 ++
 rtl/qsn_merge_len17_if.sv | 27 ++
 rtl/qsn_merge_len17_mask_gen.sv | 22 ++
 rtl/qsn_merge_len17.sv | 102 ++++++++++
 4 files changed

// File: rtl/qsn_merge_len17_pkg.sv
// Shared constants, stage-1 record and select helper for the 17-lane QSN merge stage.
package qsn_pkg;

   localparam int QSN_Z       = 17;
   localparam int QSN_SHIFT_W = 5;

   typedef logic [QSN_SHIFT_W-1:0] shift_t;

   typedef struct packed {
      logic   v;
      shift_t s;
      logic   e;
   } stage1_t;

   // Right shifter supplies the wrapped lanes, so it rotates by the complement of s.
   function automatic shift_t right_sel(input shift_t s, input int z);
      shift_t r;
      if (s == {QSN_SHIFT_W{1'b0}}) begin
         r = {QSN_SHIFT_W{1'b0}};
      end else begin
         r = shift_t'(z) - s;
      end
      return r;
   endfunction

endpackage

// File: rtl/qsn_merge_len17_if.sv
// Request, select and merged-result bundle between the address generator, shifters and merge stage.
interface qsn_merge_len17_if
   import qsn_pkg::*;
#(
   parameter int Z       = QSN_Z,
   parameter int SHIFT_W = QSN_SHIFT_W
);
   logic               in_valid;
   logic [SHIFT_W-1:0] shift_factor;
   logic [SHIFT_W-1:0] sel_left;
   logic [SHIFT_W-1:0] sel_right;
   logic [Z-1:0]       left_in;
   logic [Z-1:0]       right_in;
   logic               out_valid;
   logic [Z-1:0]       out_data;
   logic               out_err;

   modport master (
      output in_valid, shift_factor, left_in, right_in,
      input  sel_left, sel_right, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, shift_factor, left_in, right_in,
      output sel_left, sel_right, out_valid, out_data, out_err
   );
endinterface

// File: rtl/qsn_merge_len17_mask_gen.sv
// Lane mask for merging left/right QSN shifter outputs; lane i comes from the left shifter when i < Z-s.
module qsn_mask_gen #(
   parameter int Z       = 17,
   parameter int SHIFT_W = 5
) (
   input  logic [SHIFT_W-1:0] s,
   output logic [Z-1:0]       mask
);

   // Lanes below Z-s are unwrapped; s=0 leaves every lane on the left shifter.
   always_comb begin
      mask = {Z{1'b0}};
      for (int i = 0; i < Z; i++) begin
         if (i < (Z - int'(s))) begin
            mask[i] = 1'b1;
         end else begin
            mask[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/qsn_merge_len17.sv
// QSN merge/control stage: select generation, latency alignment and registered lane merge.
// Optional illegal-shift counter on err_cnt is compiled in with QSN_MERGE_ERRCNT_EN.
module qsn_merge_len17
   import qsn_pkg::*;
#(
   parameter int Z         = QSN_Z,
   parameter int SHIFT_W   = QSN_SHIFT_W,
   parameter int OUT_CNT_W = 8
) (
   input  logic               sys_clk,
   input  logic               rst,
   qsn_merge_len17_if.slave   bus
`ifdef QSN_MERGE_ERRCNT_EN
   ,
   output logic [OUT_CNT_W-1:0] err_cnt
`endif
);

   logic               illegal_s;
   logic [SHIFT_W-1:0] s_eff_s;
   logic [SHIFT_W-1:0] sel_right_s;
   stage1_t            stage1_r;
   logic [Z-1:0]       mask_s;
   logic [Z-1:0]       merged_s;
   logic               out_valid_r;
   logic [Z-1:0]       out_data_r;
   logic               out_err_r;

   // Out-of-range shifts fall back to a pass-through rotation.
   always_comb begin
      illegal_s = (bus.shift_factor >= SHIFT_W'(Z));
      if (illegal_s) begin
         s_eff_s = {SHIFT_W{1'b0}};
      end else begin
         s_eff_s = bus.shift_factor;
      end
      sel_right_s = SHIFT_W'(right_sel(shift_t'(s_eff_s), Z));
   end

   assign bus.sel_left  = s_eff_s;
   assign bus.sel_right = sel_right_s;

   // Stage 1 lines up the request with the shifters' one-cycle latency.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         stage1_r <= '{v: 1'b0, s: {QSN_SHIFT_W{1'b0}}, e: 1'b0};
      end else begin
         stage1_r.v <= bus.in_valid;
         stage1_r.s <= shift_t'(s_eff_s);
         stage1_r.e <= bus.in_valid & illegal_s;
      end
   end

   qsn_mask_gen #(
      .Z       (Z),
      .SHIFT_W (SHIFT_W)
   ) u_mask_gen (
      .s    (SHIFT_W'(stage1_r.s)),
      .mask (mask_s)
   );

   assign merged_s = (bus.left_in & mask_s) | (bus.right_in & ~mask_s);

   // Stage 2 captures the merged result; data holds across idle cycles.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {Z{1'b0}};
         out_err_r   <= 1'b0;
      end else begin
         out_valid_r <= stage1_r.v;
         out_err_r   <= stage1_r.e;
         if (stage1_r.v) begin
            out_data_r <= merged_s;
         end else begin
            out_data_r <= out_data_r;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_err   = out_err_r;

`ifdef QSN_MERGE_ERRCNT_EN
   logic [OUT_CNT_W-1:0] err_cnt_r;

   // Saturating count of illegal requests, cleared only by reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         err_cnt_r <= {OUT_CNT_W{1'b0}};
      end else if (stage1_r.e && (err_cnt_r != {OUT_CNT_W{1'b1}})) begin
         err_cnt_r <= err_cnt_r + OUT_CNT_W'(1);
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt = err_cnt_r;
`endif

endmodule
